// File: rtl/game_tick_scheduler.sv
// game_tick_scheduler
// Derives ball, paddle and frame ticks from the pulse timer's base_pulse,
// runs the IDLE/RUN/PAUSE/OVER game state machine and holds the saturating
// speed level that shortens the ball divider. All outputs are registered,
// so every tick appears one cycle after the base_pulse that produced it.
module game_tick_scheduler #(
  parameter int BALL_DIV_INIT = 8,
  parameter int BALL_DIV_STEP = 1,
  parameter int BALL_DIV_MIN  = 2,
  parameter int PADDLE_DIV    = 4,
  parameter int MAX_LEVEL     = 6,
  parameter int LEVEL_W       = 3,
  parameter int DIV_W         = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               base_pulse,
  input  logic               start,
  input  logic               pause_toggle,
  input  logic               level_up,
  input  logic               game_over,
  output logic               timer_clear,
  output logic               ball_tick,
  output logic               paddle_tick,
  output logic               frame_tick,
  output logic               running,
  output logic [LEVEL_W-1:0] speed_level,
  output logic [1:0]         state
);

  localparam int WW = DIV_W + LEVEL_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   ball_cnt_q, ball_cnt_d;
  logic [DIV_W-1:0]   paddle_cnt_q, paddle_cnt_d;
  logic [LEVEL_W-1:0] speed_level_q, speed_level_d;
  logic               timer_clear_q, timer_clear_d;
  logic               ball_tick_q, ball_tick_d;
  logic               paddle_tick_q, paddle_tick_d;
  logic               frame_tick_q, frame_tick_d;
  logic               running_q, running_d;

  logic [WW-1:0]      level_w;
  logic [WW-1:0]      step_prod;
  logic [WW-1:0]      ball_div;
  logic [WW-1:0]      ball_limit;
  logic [LEVEL_W-1:0] level_next;

  // Ball divider shrinks with level but is clamped at the floor; the test is done before subtracting so it can never wrap.
  always_comb begin
    level_w   = WW'(speed_level_q);
    step_prod = level_w * WW'(BALL_DIV_STEP);
    if (step_prod + WW'(BALL_DIV_MIN) > WW'(BALL_DIV_INIT)) begin
      ball_div = WW'(BALL_DIV_MIN);
    end else begin
      ball_div = WW'(BALL_DIV_INIT) - step_prod;
    end
    ball_limit = ball_div - WW'(1);
    level_next = (speed_level_q < LEVEL_W'(MAX_LEVEL)) ? speed_level_q + LEVEL_W'(1)
                                                       : speed_level_q;
  end

  // Next-state logic: game FSM, divider counters, speed level and tick pulses.
  always_comb begin
    state_d       = state_q;
    ball_cnt_d    = ball_cnt_q;
    paddle_cnt_d  = paddle_cnt_q;
    speed_level_d = speed_level_q;
    timer_clear_d = 1'b0;
    ball_tick_d   = 1'b0;
    paddle_tick_d = 1'b0;
    frame_tick_d  = 1'b0;

    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          state_d       = ST_RUN;
          timer_clear_d = 1'b1;
          ball_cnt_d    = '0;
          paddle_cnt_d  = '0;
          speed_level_d = '0;
        end
      end

      ST_RUN: begin
        if (game_over) begin
          state_d = ST_OVER;
        end else if (pause_toggle) begin
          state_d = ST_PAUSE;
        end else if (base_pulse) begin
          frame_tick_d = 1'b1;
          if (WW'(ball_cnt_q) >= ball_limit) begin
            ball_tick_d = 1'b1;
            ball_cnt_d  = '0;
          end else begin
            ball_cnt_d  = ball_cnt_q + DIV_W'(1);
          end
          if (paddle_cnt_q >= DIV_W'(PADDLE_DIV - 1)) begin
            paddle_tick_d = 1'b1;
            paddle_cnt_d  = '0;
          end else begin
            paddle_cnt_d  = paddle_cnt_q + DIV_W'(1);
          end
        end
        if (level_up) begin
          speed_level_d = level_next;
        end
      end

      ST_PAUSE: begin
        if (game_over) begin
          state_d = ST_OVER;
        end else if (pause_toggle) begin
          state_d = ST_RUN;
        end else begin
          frame_tick_d = base_pulse;
        end
        if (level_up) begin
          speed_level_d = level_next;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    running_d = (state_d == ST_RUN);
  end

  // State and output registers; reset drops straight back to an idle, silent scheduler.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      ball_cnt_q    <= '0;
      paddle_cnt_q  <= '0;
      speed_level_q <= '0;
      timer_clear_q <= 1'b0;
      ball_tick_q   <= 1'b0;
      paddle_tick_q <= 1'b0;
      frame_tick_q  <= 1'b0;
      running_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ball_cnt_q    <= ball_cnt_d;
      paddle_cnt_q  <= paddle_cnt_d;
      speed_level_q <= speed_level_d;
      timer_clear_q <= timer_clear_d;
      ball_tick_q   <= ball_tick_d;
      paddle_tick_q <= paddle_tick_d;
      frame_tick_q  <= frame_tick_d;
      running_q     <= running_d;
    end
  end

  assign timer_clear = timer_clear_q;
  assign ball_tick   = ball_tick_q;
  assign paddle_tick = paddle_tick_q;
  assign frame_tick  = frame_tick_q;
  assign running     = running_q;
  assign speed_level = speed_level_q;
  assign state       = state_q;

endmodule
